// File: rtl/push_pull_pkg.sv
// Shared sizing helpers for the push-pull interface stages.
// Purely elaboration-time; no logic of its own.
// Used by both the upstream output stage and the sink-side FIFO so their depths always agree.
package push_pull_pkg;

  // Ceiling log2 with a floor of 1 bit, so tiny depths still get a usable pointer.
  function automatic int ppLog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) begin
      w = w + 1;
    end
    return w;
  endfunction

  // Credit depth of the interface: two input-side register stages plus the
  // round trip of the credit pulse, less two when the input registers are removed.
  function automatic int ppFifoDepth(input int extra, input int noInputRegs);
    return extra + ((noInputRegs != 0) ? 2 : 4);
  endfunction

endpackage

// File: rtl/push_pull_fifo_mem.sv
// Storage array for the push-pull sink FIFO: one synchronous write port, one async read port.
// Latency: write lands on the rising edge; read data follows rdAddr combinationally.
// Backpressure: none here; the caller only raises wrEn for a slot it owns.
//
// Ports: mclk clock; wrEn/wrAddr/wrData write port; rdAddr/rdData read port.
// Contents are deliberately not reset.
module push_pull_fifo_mem #(
  parameter int dataWidth = 128,
  parameter int depth     = 4,
  parameter int addrWidth = 2
) (
  input  logic                 mclk,
  input  logic                 wrEn,
  input  logic [addrWidth-1:0] wrAddr,
  input  logic [dataWidth-1:0] wrData,
  input  logic [addrWidth-1:0] rdAddr,
  output logic [dataWidth-1:0] rdData
);

  logic [dataWidth-1:0] mem [depth];

  always_ff @(posedge mclk) begin
    if (wrEn) begin
      mem[wrAddr] <= wrData;
    end
  end

  assign rdData = mem[rdAddr];

endmodule

// File: rtl/push_pull_fifo_in.sv
// Sink side of the push-pull interface: show-ahead FIFO fed by upstream pushes, credit returned per pop.
// Latency: push visible to parent 2 cycles later (1 without input regs); credit pulse 1 cycle after pop.
// Backpressure: credit based; upstream never pushes more than fifoDepth unreturned words.
//
// Ports: mclk/mresetN clock and async active-low reset; readRun_r run enable (low flushes);
// clearErrors_r clears sticky errors; xferFromPrev/dataFromPrev push from upstream;
// popFromParent consumes head; reqToPrev credit pulse; dataValidToParent/dataToParent head word;
// fifoCount occupancy; overflowError/underflowError sticky error flags.
module push_pull_fifo_in
  import push_pull_pkg::*;
#(
  parameter int dataWidth      = 128,
  parameter int extraFifoDepth = 0,
  parameter int noInputRegs    = 0
) (
  input  logic                 mclk,
  input  logic                 mresetN,
  input  logic                 readRun_r,
  input  logic                 clearErrors_r,
  input  logic                 xferFromPrev,
  input  logic [dataWidth-1:0] dataFromPrev,
  input  logic                 popFromParent,
  output logic                 reqToPrev,
  output logic                 dataValidToParent,
  output logic [dataWidth-1:0] dataToParent,
  output logic [ppLog2(ppFifoDepth(extraFifoDepth, noInputRegs) + 1)-1:0] fifoCount,
  output logic                 overflowError,
  output logic                 underflowError
);

  localparam int fifoDepth = ppFifoDepth(extraFifoDepth, noInputRegs);
  localparam int ptrWidth  = ppLog2(fifoDepth);
  localparam int cntWidth  = ppLog2(fifoDepth + 1);
  localparam logic [ptrWidth-1:0] lastPtr   = ptrWidth'(fifoDepth - 1);
  localparam logic [cntWidth-1:0] fullCount = cntWidth'(fifoDepth);

  logic                 xferR;
  logic [dataWidth-1:0] dataR;
  logic [ptrWidth-1:0]  wrPtr;
  logic [ptrWidth-1:0]  rdPtr;
  logic [dataWidth-1:0] headWord;
  logic                 isFull;
  logic                 push;
  logic                 pop;
  logic                 wrEn;
  logic                 overflowEvent;
  logic                 underflowEvent;

  // Depth need not be a power of two, so pointers wrap explicitly.
  function automatic logic [ptrWidth-1:0] ptrInc(input logic [ptrWidth-1:0] p);
    return (p == lastPtr) ? '0 : p + ptrWidth'(1);
  endfunction

  // Input stage: registered copy of the upstream push, or straight wires.
  generate
    if (noInputRegs == 0) begin : gInReg
      always_ff @(posedge mclk or negedge mresetN) begin
        if (!mresetN) begin
          xferR <= 1'b0;
          dataR <= '0;
        end else begin
          // Cleared while stopped so a stale strobe cannot push after restart.
          xferR <= xferFromPrev & readRun_r;
          dataR <= dataFromPrev;
        end
      end
    end else begin : gInWire
      assign xferR = xferFromPrev;
      assign dataR = dataFromPrev;
    end
  endgenerate

  assign dataValidToParent = (fifoCount != '0);
  assign isFull            = (fifoCount == fullCount);

  assign push = xferR & readRun_r;
  // Pop only counts against a non-empty FIFO; no fall-through of a same-cycle push.
  assign pop  = popFromParent & dataValidToParent & readRun_r;
  // At full a simultaneous pop frees the slot the write lands in (wrPtr == rdPtr there).
  assign wrEn = push & (~isFull | pop);

  assign overflowEvent  = push & isFull & ~pop;
  assign underflowEvent = popFromParent & ~dataValidToParent & readRun_r;

  push_pull_fifo_mem #(
    .dataWidth (dataWidth),
    .depth     (fifoDepth),
    .addrWidth (ptrWidth)
  ) uMem (
    .mclk   (mclk),
    .wrEn   (wrEn),
    .wrAddr (wrPtr),
    .wrData (dataR),
    .rdAddr (rdPtr),
    .rdData (headWord)
  );

  // Memory is never cleared, so mask the head to zero when there is nothing valid.
  assign dataToParent = dataValidToParent ? headWord : '0;

  always_ff @(posedge mclk or negedge mresetN) begin
    if (!mresetN) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      reqToPrev <= 1'b0;
    end else if (!readRun_r) begin
      wrPtr     <= '0;
      rdPtr     <= '0;
      fifoCount <= '0;
      reqToPrev <= 1'b0;
    end else begin
      if (wrEn) begin
        wrPtr <= ptrInc(wrPtr);
      end
      if (pop) begin
        rdPtr <= ptrInc(rdPtr);
      end
      if (wrEn && !pop) begin
        fifoCount <= fifoCount + cntWidth'(1);
      end else if (pop && !wrEn) begin
        fifoCount <= fifoCount - cntWidth'(1);
      end
      // One credit per consumed word.
      reqToPrev <= pop;
    end
  end

  // A new event in the same cycle as a clear wins, so no error is lost.
  always_ff @(posedge mclk or negedge mresetN) begin
    if (!mresetN) begin
      overflowError  <= 1'b0;
      underflowError <= 1'b0;
    end else begin
      overflowError  <= (overflowError & ~clearErrors_r) | overflowEvent;
      underflowError <= (underflowError & ~clearErrors_r) | underflowEvent;
    end
  end

endmodule

// File: doc/push_pull_fifo_in.md
# push_pull_fifo_in

Sink side of the push-pull interface: receives pushed words (`xferFromPrev`, `dataFromPrev`) from an upstream push-pull output stage into a local show-ahead FIFO. Each word the parent pops is returned to the upstream stage as a one-cycle `reqToPrev` pulse, which is the credit the upstream stage's word counter consumes. The FIFO depth matches the upstream credit depth exactly, so an interface without errors never overflows. It sits directly downstream of a push-pull output stage and feeds its parent module.

## Interface
- `dataWidth`, 128, word width.
- `extraFifoDepth`, 0, extra depth beyond basic operation; must equal the upstream stage's setting.
- `noInputRegs`, 0, 1 removes the input register on `xferFromPrev`/`dataFromPrev`; must equal the upstream stage's setting.
- `mclk` in 1 — single clock, rising edge.
- `mresetN` in 1 — reset, asynchronous, active-low.
- `readRun_r` in 1 — run enable; low flushes the FIFO.
- `clearErrors_r` in 1 — clears sticky errors.
- `xferFromPrev` in 1 — push strobe from upstream.
- `dataFromPrev` in dataWidth — push data.
- `popFromParent` in 1 — parent consumes the head word this cycle.
- `reqToPrev` out 1 — registered credit return, one pulse per accepted pop.
- `dataValidToParent` out 1 — FIFO not empty.
- `dataToParent` out dataWidth — head word (show-ahead).
- `fifoCount` out log2(fifoDepth+1) — occupancy.
- `overflowError` out 1 — sticky; push while full.
- `underflowError` out 1 — sticky; pop while empty.

## Operation
- fifoDepth = extraFifoDepth + (noInputRegs ? 2 : 4). This is the same formula the upstream credit counter uses.
- Input stage:
  - noInputRegs=0: `xfer_r`/`data_r` are registered copies. `xfer_r` resets to 0 and is cleared while `readRun_r`=0.
  - noInputRegs=1: `xfer_r`/`data_r` are wires.
- Push = `xfer_r & readRun_r`. Pop = `popFromParent & dataValidToParent & readRun_r`.
- Storage is a circular buffer with wrPtr/rdPtr of width log2(fifoDepth). Each pointer wraps explicitly from fifoDepth-1 to 0, because fifoDepth is not necessarily a power of 2.
- fifoCount rules:
  - +1 on push only.
  - −1 on pop only.
  - Unchanged on push and pop together. This is legal at full (slot freed) and at count ≥ 1.
- Push while full with no pop: word dropped, pointers/count unchanged, `overflowError` set.
- `popFromParent` while empty: ignored, no `reqToPrev`, `underflowError` set when `readRun_r`=1. Push and pop in the same cycle while empty counts as pop-while-empty: there is no fall-through.
- `dataToParent` = mem[rdPtr] when `dataValidToParent`=1, else 0.
- Sticky errors: err <= (err & ~clearErrors_r) | newEvent. If clear and a new event occur in the same cycle, the error stays set.
- `readRun_r`=0:
  - count and pointers go to 0 on the next edge.
  - pushes are ignored and `reqToPrev` is forced 0.
  - memory contents are not cleared.

## Timing
- Reset values: `reqToPrev`, `dataValidToParent`, `fifoCount`, both errors, pointers and `xfer_r` are all 0. `dataToParent` = 0. Memory is not reset.
- Push latency, `xferFromPrev` high in cycle t:
  - noInputRegs=0: written at end of t+1; `dataValidToParent` high in t+2.
  - noInputRegs=1: `dataValidToParent` high in t+1.
- Pop accepted in cycle t: `reqToPrev` high in t+1 for exactly one cycle per pop. Back-to-back pops give back-to-back pulses.
- The head advances on the edge ending t. The next word is visible in t+1.
- Reset asserted mid-operation: all state clears immediately and asynchronously. The upstream stage must be held with `readRun_r` low in the same way.

## Structure
- Shared package `push_pull_pkg`:
  - `ppFifoDepth(extra, noInputRegs)` function, shared with the upstream stage so the two depths can never diverge.
  - log2 helper.
- Sub-module `push_pull_fifo_mem`: dataWidth × fifoDepth register array with one write and one async read port, no reset.
- Top level holds the input regs, pointers, count, credit return and errors.

## Test plan
- Reset with `extraFifoDepth`=0, noInputRegs=0 (depth 4): push 4 words A..D, no pops → count=4, no error. Pop 4 → data A,B,C,D in order, 4 `reqToPrev` pulses each one cycle after its pop.
- Depth 4, count=4: push and pop in the same cycle → count stays 4, no `overflowError`, head advances.
- Depth 4, count=4: push with no pop → word dropped, `overflowError`=1. Assert `clearErrors_r` for 1 cycle → error 0.
- Empty FIFO: `popFromParent`=1 → `underflowError`=1, `reqToPrev` stays 0, count stays 0.
- `extraFifoDepth`=1, noInputRegs=1 (depth 3): 7 pushes interleaved with 7 pops → pointer wrap 2→0 exercised, data order preserved, `dataValidToParent` one cycle after each push into an empty FIFO.
- count=2 mid-stream: drop `readRun_r` → count=0 next cycle, no `reqToPrev`. Assert `mresetN`=0 mid-push → all outputs 0 immediately.
